output_arbiter_vc: RTL and testbench
====================================

// Module: output_arbiter_vc
// PURPOSE
//  Per-output-port arbiter of the VC switch; consumes per-input VC/priority request vectors from input queues.
//  Picks one input+channel per packet, gated by per-channel downstream credits.
//  Issues a 1-cycle cts with selected input/channel, then holds the grant until the packet's last flit.
// PARAMETERS
//  vc_num      3  virtual channels per priority
//  prio_num    2  priority levels (prio_num-1 = highest)
//  input_num   4  switch inputs competing for this output
//  CREDIT_W    4  credit counter width
//  CREDIT_INIT 8  per-channel credits after reset (packets); must be < 2**CREDIT_W
//  AGE_LIMIT   16 wait cycles before age boost (OUTARB_AGE_BOOST_EN only)
// PORTS
//  clk               in  1                             single clock
//  reset             in  1                             reset; synchronous, active-high
//  i_request[input_num] in vc_num*prio_num            per-input requests; bit k: prio=k/vc_num, vc=k%vc_num
//  i_last            in  1                             last flit of granted packet forwarded this cycle
//  i_credit_return   in  vc_num*prio_num               1 credit returned per set bit, per channel
//  o_cts             out 1                             1-cycle pulse: grant issued
//  o_selected_input  out $clog2(input_num)             granted input; stable from cts to last
//  o_selected_ch     out $clog2(vc_num*prio_num)       granted channel index k; stable from cts to last
//  o_busy            out 1                             grant outstanding (GRANT or BUSY)
//  o_credit_err      out 1                             sticky: credit return overflow
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state IDLE, all outputs 0, rr_ptr=0, every credit=CREDIT_INIT, o_credit_err=0.
//  Eligible bit k of input i: i_request[i][k] & credit[k]!=0.
//  Per-input candidate: highest prio with an eligible bit; within it, lowest vc.
//  Winner: highest candidate prio among inputs; ties -> round-robin, first input at/after rr_ptr (wrap).
//  FSM:
//   IDLE : any eligible -> latch winner input/ch, go GRANT; else stay.
//   GRANT: o_cts=1 for this single cycle; credit[ch]-=1; i_last=1 -> IDLE, else BUSY.
//   BUSY : hold selection; i_last=1 -> IDLE; else stay.
//   On leaving to IDLE: rr_ptr = selected_input+1 mod input_num.
//  Latency: eligible request in IDLE cycle n -> o_cts at n+1. Min 2-cycle gap cts-to-cts (IDLE between).
//  i_last ignored in IDLE. Request drop after latch does not cancel grant; packet completes.
//  Request drop while IDLE: not considered that cycle; no grant issued for it.
//  Credits: decrement at GRANT, increment per i_credit_return bit.
//   Same-cycle decrement + return on same channel -> unchanged.
//   Return at CREDIT_INIT -> held at CREDIT_INIT, o_credit_err set until reset.
//   Channel at 0 credits never selected; other channels still serve.
//  o_selected_input/o_selected_ch keep last grant value in IDLE; o_busy=0 in IDLE.
//  Reset mid-packet: immediate return to IDLE; credits reload; no cts that cycle.
// CONFIGURATION
//  OUTARB_AGE_BOOST_EN defined:
//   per-input age counter, +1 per cycle input has eligible bits but is not winner; clears when granted or no eligible bits.
//   Counter saturates at AGE_LIMIT; saturated input's candidate treated as prio above prio_num-1.
//   Boosted ties -> round-robin.
//  Not defined: no age counters; pure priority+round-robin as above.
// TESTING
//  1 single input 0 req bit 4 (prio1 vc1), credits 8 -> cts next cycle, sel_input=0, sel_ch=4, credit[4]=7, busy until i_last.
//  2 inputs 0..3 all req bit 0, i_last 2 cycles after each cts -> grants 0,1,2,3,0 in order.
//  3 input1 bit0 (prio0), input2 bit3 (prio1) -> input2 wins; after its last, input1 granted.
//  4 credit[0]=0 by 8 grants; req bit0 only -> no cts; pulse i_credit_return[0] -> cts next-next cycle; return at 8 -> o_credit_err=1.
//  5 i_last in GRANT cycle -> IDLE next cycle; reset asserted in BUSY -> IDLE, credits=8, o_busy=0.
//  6 (AGE_BOOST_EN, AGE_LIMIT=16) input0 prio0 held vs continuous prio1 traffic -> input0 granted within 16 cycles of saturation.

Source files
------------

// File: rtl/output_arbiter_vc.sv
// Per-output-port VC arbiter: priority + round-robin input selection gated by downstream credits.
// Optional age boost for starved inputs under `OUTARB_AGE_BOOST_EN.
module output_arbiter_vc #(
  parameter int unsigned vc_num      = 3,
  parameter int unsigned prio_num    = 2,
  parameter int unsigned input_num   = 4,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned CREDIT_INIT = 8,
  parameter int unsigned AGE_LIMIT   = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [vc_num*prio_num-1:0]                  i_request [input_num],
  input  logic                                        i_last,
  input  logic [vc_num*prio_num-1:0]                  i_credit_return,
  output logic                                        o_cts,
  output logic [((input_num > 1) ? $clog2(input_num) : 1)-1:0] o_selected_input,
  output logic [$clog2(vc_num*prio_num)-1:0]          o_selected_ch,
  output logic                                        o_busy,
  output logic                                        o_credit_err
);
  localparam int unsigned CH_NUM = vc_num * prio_num;
  localparam int unsigned IN_W   = (input_num > 1) ? $clog2(input_num) : 1;
  localparam int unsigned CH_W   = $clog2(CH_NUM);
  localparam int unsigned PR_W   = $clog2(prio_num + 1);

  if (CREDIT_INIT >= 2**CREDIT_W || AGE_LIMIT == 0) begin : g_bad_cfg
    $error("output_arbiter_vc: CREDIT_INIT must fit CREDIT_W and AGE_LIMIT must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit [CH_NUM];
  logic [CH_NUM-1:0]   credit_dec;
  logic [IN_W-1:0]     rr_ptr;
  logic [input_num-1:0] cand_vld;
  logic [CH_W-1:0]     cand_ch [input_num];
  logic [PR_W-1:0]     cand_pr [input_num];
  logic                win_vld;
  logic [IN_W-1:0]     win_in;
  logic [CH_W-1:0]     win_ch;
  logic [PR_W-1:0]     best_pr;
  logic [IN_W-1:0]     idx;
  logic                latch;

`ifdef OUTARB_AGE_BOOST_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age [input_num];
`endif

  // Per-input candidate: highest eligible prio, lowest vc within it (later loop hits overwrite).
  always_comb begin
    for (int i = 0; i < input_num; i++) begin
      cand_vld[i] = 1'b0;
      cand_ch[i]  = '0;
      cand_pr[i]  = '0;
      for (int p = 0; p < prio_num; p++) begin
        for (int v = vc_num - 1; v >= 0; v--) begin
          if (i_request[i][p*vc_num+v] && (credit[p*vc_num+v] != '0)) begin
            cand_vld[i] = 1'b1;
            cand_ch[i]  = CH_W'(p*vc_num + v);
            cand_pr[i]  = PR_W'(p);
          end
        end
      end
`ifdef OUTARB_AGE_BOOST_EN
      if (age[i] == AGE_W'(AGE_LIMIT)) cand_pr[i] = PR_W'(prio_num);
`endif
    end
  end

  // Winner: scan from rr_ptr, only a strictly higher prio displaces, so ties go round-robin.
  always_comb begin
    win_vld = 1'b0;
    win_in  = '0;
    win_ch  = '0;
    best_pr = '0;
    idx     = '0;
    for (int j = 0; j < input_num; j++) begin
      idx = IN_W'((32'(rr_ptr) + 32'(j)) % input_num);
      if (cand_vld[idx] && (!win_vld || cand_pr[idx] > best_pr)) begin
        win_vld = 1'b1;
        win_in  = idx;
        win_ch  = cand_ch[idx];
        best_pr = cand_pr[idx];
      end
    end
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_next = GRANT;
          latch      = 1'b1;
        end
      end
      GRANT:   state_next = i_last ? IDLE : BUSY;
      BUSY:    if (i_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      o_cts            <= 1'b0;
      o_busy           <= 1'b0;
      o_selected_input <= '0;
      o_selected_ch    <= '0;
      rr_ptr           <= '0;
    end else begin
      state  <= state_next;
      o_cts  <= latch;
      o_busy <= (state_next != IDLE);
      if (latch) begin
        o_selected_input <= win_in;
        o_selected_ch    <= win_ch;
      end
      if (state != IDLE && state_next == IDLE)
        rr_ptr <= IN_W'((32'(o_selected_input) + 32'd1) % input_num);
    end
  end

  always_comb begin
    for (int k = 0; k < CH_NUM; k++)
      credit_dec[k] = (state == GRANT) && (o_selected_ch == CH_W'(k));
  end

  // Credit counters; a return on a full channel saturates and flags the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CH_NUM; k++) credit[k] <= CREDIT_W'(CREDIT_INIT);
      o_credit_err <= 1'b0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (i_credit_return[k] && !credit_dec[k]) begin
          if (credit[k] == CREDIT_W'(CREDIT_INIT)) o_credit_err <= 1'b1;
          else                                     credit[k] <= credit[k] + CREDIT_W'(1);
        end else if (credit_dec[k] && !i_credit_return[k]) begin
          credit[k] <= credit[k] - CREDIT_W'(1);
        end
      end
    end
  end

`ifdef OUTARB_AGE_BOOST_EN
  // Age counts cycles an input waits with eligible work; saturates at AGE_LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < input_num; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < input_num; i++) begin
        if (!cand_vld[i] || (latch && win_in == IN_W'(i))) age[i] <= '0;
        else if (age[i] != AGE_W'(AGE_LIMIT))              age[i] <= age[i] + AGE_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_output_arbiter_vc.sv
// Directed self-checking bench for output_arbiter_vc (age-boost case built with OUTARB_AGE_BOOST_EN).
module tb_output_arbiter_vc;
  logic       clk;
  logic       reset;
  logic [5:0] req [4];
  logic       i_last;
  logic [5:0] ret;
  logic       o_cts;
  logic [1:0] o_selected_input;
  logic [2:0] o_selected_ch;
  logic       o_busy;
  logic       o_credit_err;

  int n_checks = 0;
  int n_pass   = 0;

  output_arbiter_vc dut (
    .clk              (clk),
    .reset            (reset),
    .i_request        (req),
    .i_last           (i_last),
    .i_credit_return  (ret),
    .o_cts            (o_cts),
    .o_selected_input (o_selected_input),
    .o_selected_ch    (o_selected_ch),
    .o_busy           (o_busy),
    .o_credit_err     (o_credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_req();
    for (int i = 0; i < 4; i++) req[i] = '0;
  endtask

  initial begin
    logic [1:0] exp_in [5];
    exp_in[0] = 2'd0; exp_in[1] = 2'd1; exp_in[2] = 2'd2; exp_in[3] = 2'd3; exp_in[4] = 2'd0;
    clk = 1'b0; i_last = 1'b0; ret = '0;
    clear_req();
    do_reset();

    // reset state
    check("rst_cts", o_cts, 0);
    check("rst_busy", o_busy, 0);
    check("rst_sel_in", o_selected_input, 0);
    check("rst_sel_ch", o_selected_ch, 0);
    check("rst_err", o_credit_err, 0);
    check("rst_credit4", dut.credit[4], 8);

    // 1: single request prio1 vc1
    req[0] = 6'b010000;
    tick();
    check("t1_cts", o_cts, 1);
    check("t1_sel_in", o_selected_input, 0);
    check("t1_sel_ch", o_selected_ch, 4);
    check("t1_busy", o_busy, 1);
    clear_req();
    tick();
    check("t1_cts_pulse", o_cts, 0);
    check("t1_busy_hold", o_busy, 1);
    check("t1_credit4", dut.credit[4], 7);
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    check("t1_idle_busy", o_busy, 0);
    check("t1_keep_ch", o_selected_ch, 4);

    // 2: round-robin among equal requests
    do_reset();
    for (int i = 0; i < 4; i++) req[i] = 6'b000001;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t2_cts", o_cts, 1);
      check("t2_sel_in", o_selected_input, exp_in[g]);
      tick();
      i_last = 1'b1;
      tick();
      i_last = 1'b0;
      check("t2_gap_cts", o_cts, 0);
    end
    clear_req();
    check("t2_credit0", dut.credit[0], 3);

    // 3: priority beats round-robin
    do_reset();
    req[1] = 6'b000001;
    req[2] = 6'b001000;
    tick();
    check("t3_sel_in_a", o_selected_input, 2);
    check("t3_sel_ch_a", o_selected_ch, 3);
    tick();
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    req[2] = '0;
    tick();
    check("t3_cts_b", o_cts, 1);
    check("t3_sel_in_b", o_selected_input, 1);
    check("t3_sel_ch_b", o_selected_ch, 0);
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    clear_req();

    // 4: credit exhaustion, other channel still serves, return, overflow
    do_reset();
    req[0] = 6'b000001;
    for (int g = 0; g < 8; g++) begin
      tick();
      check("t4_drain_cts", o_cts, 1);
      i_last = 1'b1;
      tick();
      i_last = 1'b0;
    end
    check("t4_credit0", dut.credit[0], 0);
    req[3] = 6'b000100;
    tick();
    check("t4_other_cts", o_cts, 1);
    check("t4_other_in", o_selected_input, 3);
    check("t4_other_ch", o_selected_ch, 2);
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    req[3] = '0;
    tick();
    check("t4_blocked_a", o_cts, 0);
    tick();
    check("t4_blocked_b", o_cts, 0);
    check("t4_blocked_busy", o_busy, 0);
    ret = 6'b000001;
    tick();
    ret = '0;
    check("t4_ret_next", o_cts, 0);
    tick();
    check("t4_ret_cts", o_cts, 1);
    check("t4_ret_ch", o_selected_ch, 0);
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    clear_req();
    ret = 6'b000010;
    tick();
    ret = '0;
    check("t4_err", o_credit_err, 1);
    check("t4_credit1_sat", dut.credit[1], 8);
    tick();
    check("t4_err_sticky", o_credit_err, 1);

    // 5: last in GRANT, then reset mid-packet
    do_reset();
    check("t5_err_clr", o_credit_err, 0);
    req[0] = 6'b000001;
    tick();
    check("t5_cts", o_cts, 1);
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    check("t5_idle_busy", o_busy, 0);
    check("t5_idle_cts", o_cts, 0);
    tick();
    check("t5_cts2", o_cts, 1);
    tick();
    check("t5_busy", o_busy, 1);
    reset = 1'b1;
    tick();
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_cts", o_cts, 0);
    check("t5_rst_credit0", dut.credit[0], 8);
    reset = 1'b0;
    clear_req();
    tick();
    check("t5_post_cts", o_cts, 0);

`ifdef OUTARB_AGE_BOOST_EN
    // 6: starved low-prio input gets boosted past continuous high-prio traffic
    begin
      logic got0;
      got0 = 1'b0;
      do_reset();
      req[0] = 6'b000001;
      req[1] = 6'b001000;
      req[2] = 6'b001000;
      for (int c = 0; c < 50 && !got0; c++) begin
        tick();
        if (o_cts && o_selected_input == 2'd0) got0 = 1'b1;
        i_last = o_cts;
        ret    = (o_cts && o_selected_ch == 3'd3) ? 6'b001000 : 6'b000000;
      end
      i_last = 1'b0;
      ret = '0;
      clear_req();
      check("t6_age_grant", got0, 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
